// File: rtl/la_ioring_seq_pkg.sv
// Shared types for the padring power sequencer: FSM state encoding and width.
package la_ioring_seq_pkg;

   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      OFF,
      SCAN_UP,
      PWR,
      PGW,
      UNISO,
      ON,
      SCAN_DN,
      ISO,
      DRAIN,
      FAULT
   } state_t;

endpackage

// File: rtl/la_ioring_seq_if.sv
// Control/status bundle between the always-on controller and the padring sequencer.
interface la_ioring_seq_if #(
   parameter int NSEG = 4,
   parameter int CW   = 8
);
   localparam int SW = (NSEG > 1) ? $clog2(NSEG) : 1;

   // No valid/ready pairing: up_req is a target level that the sequencer follows,
   // and every status output is a level that is valid in every cycle.
   logic            up_req;
   logic [NSEG-1:0] seg_mask;
   logic [CW-1:0]   settle;
   logic [NSEG-1:0] pg;
   logic [NSEG-1:0] seg_en;
   logic [NSEG-1:0] seg_iso;
   logic            busy;
   logic            ring_on;
   logic            fault;
   logic [SW-1:0]   fault_seg;

   modport master (
      output up_req, seg_mask, settle, pg,
      input  seg_en, seg_iso, busy, ring_on, fault, fault_seg
   );

   modport slave (
      input  up_req, seg_mask, settle, pg,
      output seg_en, seg_iso, busy, ring_on, fault, fault_seg
   );

endinterface

// File: rtl/la_ioring_seq_timer.sv
// Loadable down-counter; a load of 0 behaves as 1, and done marks the last counted cycle.
module la_ioring_seq_timer
   import la_ioring_seq_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= (value == '0) ? W'(1) : value;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   // A step loaded with N stays in its state for exactly N cycles.
   assign done = (cnt == W'(1));

endmodule

// File: rtl/la_ioring_seq.sv
// Padring segment power sequencer: ascending power-up, descending power-down.
// Optional power-good timeout with sticky fault when LA_IORING_PGTIMEOUT_EN is defined.
module la_ioring_seq
   import la_ioring_seq_pkg::*;
#(
   parameter int NSEG = 4,
   parameter int CW   = 8,
   parameter int TMO  = 1024
) (
   input  logic           clk,
   input  logic           rst,
   la_ioring_seq_if.slave io,
   output state_t         dbg_state
);

   localparam int SW = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam int IW = $clog2(NSEG + 1);
   localparam logic [IW-1:0] TOP  = IW'(NSEG);
   localparam logic [IW-1:0] LAST = IW'(NSEG - 1);

   if (NSEG < 1 || NSEG > 16 || TMO < 1) begin : g_bad_param
      $error("la_ioring_seq: NSEG must be 1..16 and TMO at least 1");
   end

   state_t          state;
   logic [IW-1:0]   idx;
   logic [SW-1:0]   sidx;
   logic [NSEG-1:0] mask_q;
   logic [NSEG-1:0] seg_en;
   logic [NSEG-1:0] seg_iso;
   logic [NSEG-1:0] pg_s1;
   logic [NSEG-1:0] pg_s2;
   logic            busy;
   logic            ring_on;
   logic            at_top;
   logic            seg_sel;
   logic            pg_ok;
   logic            st_done;
   logic            st_load;

   assign sidx    = idx[SW-1:0];
   assign at_top  = (idx == TOP);
   assign seg_sel = mask_q[sidx];
   assign pg_ok   = pg_s2[sidx];

   always_comb begin
      st_load = 1'b0;
      case (state)
         SCAN_UP: st_load = io.up_req && !at_top && seg_sel;
         PGW:     st_load = pg_ok;
         SCAN_DN: st_load = !io.up_req && seg_sel;
         ISO:     st_load = st_done;
         default: st_load = 1'b0;
      endcase
   end

   la_ioring_seq_timer #(.W(CW)) u_settle (
      .clk   (clk),
      .rst   (rst),
      .load  (st_load),
      .value (io.settle),
      .done  (st_done)
   );

`ifdef LA_IORING_PGTIMEOUT_EN
   localparam int TW = $clog2(TMO + 1);
   logic          to_done;
   logic          fault_q;
   logic [SW-1:0] fault_seg_q;

   la_ioring_seq_timer #(.W(TW)) u_tmo (
      .clk   (clk),
      .rst   (rst),
      .load  (state == PWR && st_done),
      .value (TW'(TMO)),
      .done  (to_done)
   );
`endif

   // The synchronizer restarts on every PGW entry, so a pg level sampled before
   // the wait began is never trusted: PGW always spends at least 3 cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pg_s1 <= '0;
         pg_s2 <= '0;
      end else if (state != PGW) begin
         pg_s1 <= '0;
         pg_s2 <= '0;
      end else begin
         pg_s1 <= io.pg;
         pg_s2 <= pg_s1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= OFF;
         idx     <= '0;
         mask_q  <= '0;
         seg_en  <= '0;
         seg_iso <= '1;
         busy    <= 1'b0;
         ring_on <= 1'b0;
`ifdef LA_IORING_PGTIMEOUT_EN
         fault_q     <= 1'b0;
         fault_seg_q <= '0;
`endif
      end else begin
         case (state)
            OFF: if (io.up_req) begin
               mask_q <= io.seg_mask;
               idx    <= '0;
               busy   <= 1'b1;
               state  <= SCAN_UP;
            end
            // idx here is the next segment to bring up; all below it are up.
            SCAN_UP: begin
               if (!io.up_req) begin
                  if (idx == '0) begin
                     busy  <= 1'b0;
                     state <= OFF;
                  end else begin
                     idx   <= idx - IW'(1);
                     state <= SCAN_DN;
                  end
               end else if (at_top) begin
                  busy    <= 1'b0;
                  ring_on <= 1'b1;
                  state   <= ON;
               end else if (seg_sel) begin
                  seg_en[sidx] <= 1'b1;
                  state        <= PWR;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            PWR: if (st_done) state <= PGW;
            PGW: begin
               if (pg_ok) begin
                  seg_iso[sidx] <= 1'b0;
                  state         <= UNISO;
               end
`ifdef LA_IORING_PGTIMEOUT_EN
               else if (to_done) begin
                  seg_en      <= '0;
                  seg_iso     <= '1;
                  busy        <= 1'b0;
                  fault_q     <= 1'b1;
                  fault_seg_q <= sidx;
                  state       <= FAULT;
               end
`endif
            end
            UNISO: if (st_done) begin
               if (io.up_req) begin
                  idx   <= idx + IW'(1);
                  state <= SCAN_UP;
               end else begin
                  state <= SCAN_DN;
               end
            end
            ON: if (!io.up_req) begin
               idx     <= LAST;
               busy    <= 1'b1;
               ring_on <= 1'b0;
               state   <= SCAN_DN;
            end
            // idx here is the highest segment that may still be up.
            SCAN_DN: begin
               if (io.up_req) begin
                  idx   <= idx + IW'(1);
                  state <= SCAN_UP;
               end else if (seg_sel) begin
                  seg_iso[sidx] <= 1'b1;
                  state         <= ISO;
               end else if (idx == '0) begin
                  busy  <= 1'b0;
                  state <= OFF;
               end else begin
                  idx <= idx - IW'(1);
               end
            end
            ISO: if (st_done) begin
               seg_en[sidx] <= 1'b0;
               state        <= DRAIN;
            end
            DRAIN: if (st_done) begin
               if (io.up_req) begin
                  state <= SCAN_UP;
               end else if (idx == '0) begin
                  busy  <= 1'b0;
                  state <= OFF;
               end else begin
                  idx   <= idx - IW'(1);
                  state <= SCAN_DN;
               end
            end
`ifdef LA_IORING_PGTIMEOUT_EN
            FAULT: if (!io.up_req) state <= OFF;
`endif
            default: state <= OFF;
         endcase
      end
   end

   a_iso_needs_en: assert property (@(posedge clk) disable iff (rst) (~seg_iso & ~seg_en) == '0);

   assign io.seg_en  = seg_en;
   assign io.seg_iso = seg_iso;
   assign io.busy    = busy;
   assign io.ring_on = ring_on;
   assign dbg_state  = state;
`ifdef LA_IORING_PGTIMEOUT_EN
   assign io.fault     = fault_q;
   assign io.fault_seg = fault_seg_q;
`else
   assign io.fault     = 1'b0;
   assign io.fault_seg = '0;
`endif

endmodule
